// File: rtl/req_ack_pkg.sv
// -----------------------------------------------------------------------------
// req_ack_pkg
// Shared types and default widths for the four-phase req/ack responder.
//   state_e   : responder FSM states (IDLE, WAIT, ACK)
//   LAT_W_DEF : default width of the latency setting
//   CNT_W_DEF : default width of the completed-handshake counter
// -----------------------------------------------------------------------------
package req_ack_pkg;

   localparam int LAT_W_DEF = 8;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_e;

endpackage : req_ack_pkg

// File: rtl/req_ack_responder_sva.sv
// -----------------------------------------------------------------------------
// req_ack_responder_sva
// Handshake protocol properties for the req/ack bus, shared with the
// initiator side. Purely observational; bind or instantiate next to the bus.
// Ports:
//   clk_i, rst_i : clock and asynchronous active-high reset
//   req_i        : request from initiator
//   ack_i        : acknowledge from responder
//   busy_i       : responder is in a handshake
//   err_i        : responder violation pulse
// -----------------------------------------------------------------------------
module req_ack_responder_sva (
   input logic clk_i,
   input logic rst_i,
   input logic req_i,
   input logic ack_i,
   input logic busy_i,
   input logic err_i
);

   // ack may only rise on an edge that sampled req high
   ack_rise_needs_req : assert property (
      @(posedge clk_i) disable iff (rst_i)
         $rose(ack_i) |-> $past(req_i)
   );

   // withdrawing req before ack while the responder is busy must be flagged
   early_drop_flags_err : assert property (
      @(posedge clk_i) disable iff (rst_i)
         $fell(req_i) && !ack_i && busy_i |=> err_i
   );

endmodule : req_ack_responder_sva

// File: rtl/req_ack_responder.sv
// -----------------------------------------------------------------------------
// req_ack_responder
// Responder end of a four-phase req/ack handshake. A request seen in IDLE
// captures the latency setting; ack rises after that many cycles and is held
// until req is withdrawn. Dropping req before ack rises is a violation.
// Ports:
//   clk_i        : clock, all state on posedge
//   rst_i        : asynchronous active-high reset
//   req_i        : level-held request from the initiator
//   lat_i        : response latency in cycles, captured at request start
//   clr_err_i    : synchronous clear of err_sticky_o (a new error wins)
//   ack_o        : registered acknowledge
//   busy_o       : high while waiting or acknowledging
//   err_o        : one-cycle pulse on an early req drop
//   err_sticky_o : latched violation flag
//   done_cnt_o   : completed handshakes, wraps
// -----------------------------------------------------------------------------
module req_ack_responder
   import req_ack_pkg::*;
#(
   parameter int LAT_W = LAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic [LAT_W-1:0] lat_i,
   input  logic             clr_err_i,
   output logic             ack_o,
   output logic             busy_o,
   output logic             err_o,
   output logic             err_sticky_o,
   output logic [CNT_W-1:0] done_cnt_o
);

   localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] done_q, done_d;

   // Next-state, latency countdown and output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      err_d   = 1'b0;
      done_d  = done_q;

      case (state_q)
         IDLE: begin
            if (req_i) begin
               if (lat_i == '0) begin
                  state_d = ACK;
                  ack_d   = 1'b1;
               end else begin
                  // lat-1 because the edge entering WAIT already counts
                  state_d = WAIT;
                  cnt_d   = lat_i - LAT_ONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            // a drop during WAIT takes priority over an expiring count
            if (!req_i) begin
               state_d = IDLE;
               err_d   = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ACK;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - LAT_ONE;
            end
         end
         ACK: begin
            if (!req_i) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               done_d  = done_q + CNT_ONE;
            end else begin
               ack_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase

      busy_d   = (state_d != IDLE);
      // set wins over a simultaneous clear
      sticky_d = err_d | (sticky_q & ~clr_err_i);
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         done_q   <= done_d;
      end
   end

   assign ack_o        = ack_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;
   assign err_sticky_o = sticky_q;
   assign done_cnt_o   = done_q;

endmodule : req_ack_responder
